// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_ctrl fetch/decode/execute controller:
// opcodes, FSM states, instruction field positions and the decode bundle.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int R1_MSB  = 11;
  localparam int R1_LSB  = 9;
  localparam int R2_MSB  = 8;
  localparam int R2_LSB  = 6;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef struct packed {
    logic is_nop;
    logic is_add;
    logic is_addi;
    logic is_st;
    logic is_ld;
    logic is_illegal;
  } dec_t;

endpackage

// File: rtl/cpu_ctrl_instr_decoder.sv
// Combinational opcode decoder: exactly one dec_t flag is set for any opcode.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_NOP:  dec.is_nop     = 1'b1;
      OP_ADD:  dec.is_add     = 1'b1;
      OP_ADDI: dec.is_addi    = 1'b1;
      OP_ST:   dec.is_st      = 1'b1;
      OP_LD:   dec.is_ld      = 1'b1;
      default: dec.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/execute controller for the NOP/ADD/ADDI/ST/LD ISA.
// Strobes (rf_we, dm_we, dm_re) are pure decodes of state and opcode, so reset drops them at once.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int DW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic [PC_W-1:0] rom_addr,
  input  logic [DW-1:0]   rom_data,
  output logic [2:0]      rf_ra1,
  output logic [2:0]      rf_ra2,
  input  logic [DW-1:0]   rf_rd1,
  input  logic [DW-1:0]   rf_rd2,
  output logic [2:0]      rf_wa,
  output logic [DW-1:0]   rf_wd,
  output logic            rf_we,
  output logic [8:0]      dm_addr,
  output logic [DW-1:0]   dm_wdata,
  output logic            dm_we,
  output logic            dm_re,
  input  logic [DW-1:0]   dm_rdata,
  output logic [DW-1:0]   ir,
  output logic [15:0]     retired,
  output logic            illegal,
  output state_t          state
);

  state_t          state_n;
  dec_t            dec;
  logic [PC_W-1:0] pc;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic [DW-1:0]   r_q;
  logic            ret_inc;

  instr_decoder u_dec (
    .opcode (ir[OPC_MSB:OPC_LSB]),
    .dec    (dec)
  );

  assign rom_addr = pc;
  assign rf_ra1   = ir[R1_MSB:R1_LSB];
  assign rf_ra2   = ir[R2_MSB:R2_LSB];
  assign rf_wa    = ir[R1_MSB:R1_LSB];
  assign rf_wd    = r_q;
  assign dm_addr  = ir[IMM_MSB:IMM_LSB];
  assign dm_wdata = a_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    rf_we   = 1'b0;
    dm_we   = 1'b0;
    dm_re   = 1'b0;
    ret_inc = 1'b0;
    case (state)
      S_FETCH:  if (run) state_n = S_DECODE;
      S_DECODE: state_n = dec.is_illegal ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (dec.is_add || dec.is_addi) begin
          state_n = S_WB;
        end else if (dec.is_ld) begin
          dm_re   = 1'b1;
          state_n = S_MEM;
        end else if (dec.is_st || dec.is_nop) begin
          dm_we   = dec.is_st;
          ret_inc = 1'b1;
          state_n = S_FETCH;
        end else begin
          state_n = S_HALT;
        end
      end
      S_MEM: state_n = S_WB;
      S_WB: begin
        rf_we   = 1'b1;
        ret_inc = 1'b1;
        state_n = S_FETCH;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
  end

  // Datapath registers; results wrap silently at DW bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      if (state == S_FETCH && run) begin
        ir <= rom_data;
        pc <= pc + PC_W'(1);
      end
      if (state == S_DECODE) begin
        a_q <= rf_rd1;
        b_q <= rf_rd2;
        if (dec.is_illegal) illegal <= 1'b1;
      end
      if (state == S_EXEC) begin
        if (dec.is_add)       r_q <= a_q + b_q;
        else if (dec.is_addi) r_q <= a_q + DW'(ir[IMM_MSB:IMM_LSB]);
      end
      if (state == S_MEM) r_q <= dm_rdata;
      if (ret_inc) retired <= retired + 16'd1;
    end
  end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle fetch/decode/execute controller that sits directly downstream of the instruction ROM. It drives the ROM address from its program counter and latches the 16-bit instruction word. It then sequences the register file and data memory to execute the four-instruction ISA: ADD, ADDI, ST and LD, with opcode 0000 as NOP. It is the control core between instruction memory, register file and data memory.

## Interface
- PC_W, 8, program counter / ROM address width; PC wraps modulo 2**PC_W.
- DW, 16, datapath and instruction width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- run  in  1  start/continue fetching; sampled only in S_FETCH.
- rom_addr  out  PC_W  instruction address, equal to pc; ROM returns rom_data combinationally.
- rom_data  in  DW  instruction word.
- rf_ra1 / rf_ra2  out  3  register read addresses, IR[11:9] / IR[8:6].
- rf_rd1 / rf_rd2  in  DW  register read data, combinational.
- rf_wa  out  3  write address, IR[11:9].
- rf_wd  out  DW  write data.
- rf_we  out  1  register write strobe, one cycle.
- dm_addr  out  9  data memory address, IR[8:0].
- dm_wdata  out  DW  store data.
- dm_we  out  1  store strobe, one cycle.
- dm_re  out  1  load strobe, one cycle; dm_rdata is valid the following cycle.
- dm_rdata  in  DW  load data.
- ir  out  DW  current instruction register.
- retired  out  16  count of completed instructions; wraps at 2**16.
- illegal  out  1  sticky flag, set on an undefined opcode.

## Operation
- Instruction fields:
  - IR[15:12] is the opcode: 0000 NOP, 0001 ADD, 0010 ADDI, 0011 ST, 0100 LD.
  - 0101–1111 are illegal.
- State machine states: S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT.
- S_FETCH
  - If run=0: stay in S_FETCH.
  - If run=1: IR<=rom_data, pc<=pc+1 (mod 2**PC_W), go to S_DECODE.
- S_DECODE
  - Latch A<=rf_rd1, B<=rf_rd2.
  - Illegal opcode: set illegal, go to S_HALT.
  - Otherwise: go to S_EXEC.
- S_EXEC
  - ADD: R<=A+B.
  - ADDI: R<=A+zext(IR[8:0]).
  - Both are 16-bit, carry discarded; next state S_WB.
  - ST: dm_we=1, dm_wdata=A; then S_FETCH.
  - LD: dm_re=1; then S_MEM.
  - NOP: S_FETCH.
- S_MEM (LD only): R<=dm_rdata; then S_WB.
- S_WB: rf_we=1, rf_wd=R, rf_wa=IR[11:9]; then S_FETCH.
- S_HALT: absorbing state; only rst_n leaves it. No strobes, pc frozen.
- retired increments on the last cycle of each legal instruction:
  - S_EXEC for NOP and ST.
  - S_WB for ADD, ADDI and LD.
- Strobes rf_we, dm_we and dm_re are decoded from state plus opcode. Each is high for exactly one cycle per instruction and never asserted together.

## Timing
- Reset values:
  - Registers: pc=0, IR=0, A=B=R=0, state=S_FETCH, retired=0, illegal=0.
  - Outputs: all strobes 0, rom_addr=0.
- Cycles per instruction: NOP 3, ST 3, ADD/ADDI 4, LD 5, all counted from the S_FETCH cycle with run=1.
- Register read-after-write: WB completes before the next S_DECODE, so no hazard logic is needed.
- run deasserted mid-instruction: the current instruction completes; the machine then holds in S_FETCH.
- rst_n asserted mid-instruction: immediate abort. Any strobe drops asynchronously and no partial write occurs. Restart fetches from address 0.
- pc wrap: fetching at address 2**PC_W−1 sets pc to 0 with no flag.
- ADDI immediate is unsigned 0–511; ADD/ADDI overflow wraps silently.

## Structure
- Shared package cpu_pkg:
  - opcode constants OP_NOP/OP_ADD/OP_ADDI/OP_ST/OP_LD;
  - state enum/encoding;
  - field position constants (opcode, r1, r2, imm/addr).
- One sub-module instr_decoder (combinational) maps the opcode to is_add/is_addi/is_st/is_ld/is_nop/is_illegal; cpu_ctrl holds the FSM, pc, IR, A/B/R and counters.

## Test plan
- Reset, then run=1, ROM all zero → rom_addr steps 0,1,2 every 3 cycles; no strobes; retired=1 after cycle 3.
- r4=5, r2=9, ROM[0]=0x1880 (ADD r4,r2) → rf_we in cycle 4, rf_wa=4, rf_wd=14; retired=1.
- r5=0xFFFE, ROM[0]=0x2A07 (ADDI r5,7) → rf_wd=0x0005 (wrap), rf_wa=5.
- ROM[0]=0x3802 (ST r4,2) with r4=14, then ROM[1]=0x4202 (LD r1,2) with memory model returning 14 → dm_we at cycle 3 with dm_addr=2, dm_wdata=14. Then dm_re at cycle 6; rf_we at cycle 8 with rf_wa=1, rf_wd=14.
- ROM[0]=0xF000 → illegal=1 after S_DECODE; state S_HALT; rom_addr stays 1 for 20 cycles; no strobes; rst_n low clears all.
- Pulse rst_n low during S_MEM of an LD → no rf_we; pc=0; state S_FETCH; next fetch from address 0.
